// File: rtl/map_row_fetcher.sv
// Avalon-MM read master that walks one row of the tile map and streams the
// row's tile indices, in column order, through a small valid/ready FIFO.
module map_row_fetcher #(
    parameter int MAP_COLS   = 40,
    parameter int MAP_ROWS   = 30,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        row,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] readdata,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [DATA_W-1:0] tile_data,
    output logic [5:0]        tile_col
);

    localparam int COL_W = 6;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAP_COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [ADDR_W-1:0] address_r;
    logic [COL_W-1:0]  issue_col_r;
    logic [COL_W-1:0]  rd_col_r;
    logic [COL_W-1:0]  pend_col_r;
    logic              read_r;
    logic              rd_pend_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
    logic [COL_W-1:0]  fifo_col_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              push_s;
    logic              pop_s;
    logic              last_pop_s;
    logic              issue_s;
    logic              row_ok_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] start_base_s;

    // Handshake, occupancy and read-issue decisions for the coming edge
    always_comb begin
        push_s       = rd_pend_r;
        pop_s        = (count_r != '0) && tile_ready;
        last_pop_s   = pop_s && (state_r == ST_DRAIN) && (fifo_col_r[rd_ptr_r] == LAST_COL);
        count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        // Reserve room for the read already on the bus plus the one about to issue
        issue_s      = (state_r == ST_FETCH) &&
                       ((count_next_s + CNT_W'(read_r)) < CNT_W'(FIFO_DEPTH));
        row_ok_s     = ({27'd0, row} < 32'(MAP_ROWS));
        start_base_s = ADDR_W'(BASE_ADDR) + ADDR_W'(row) * ADDR_W'(MAP_COLS);
    end

    // Row-walk FSM with registered Avalon and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            row_base_r  <= '0;
            address_r   <= '0;
            issue_col_r <= '0;
            rd_col_r    <= '0;
            read_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            read_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (row_ok_s) begin
                            row_base_r  <= start_base_s;
                            address_r   <= start_base_s;
                            rd_col_r    <= COL_W'(0);
                            issue_col_r <= COL_W'(1);
                            read_r      <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= (MAP_COLS > 1) ? ST_FETCH : ST_DRAIN;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue_s) begin
                        read_r      <= 1'b1;
                        address_r   <= row_base_r + ADDR_W'(issue_col_r);
                        rd_col_r    <= issue_col_r;
                        if (issue_col_r == LAST_COL) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            issue_col_r <= issue_col_r + COL_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_pop_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO: readdata lands one cycle after its read, tagged with its column
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_pend_r  <= 1'b0;
            pend_col_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= '0;
                fifo_col_r[i]  <= '0;
            end
        end else begin
            rd_pend_r  <= read_r;
            pend_col_r <= rd_col_r;
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= readdata;
                fifo_col_r[wr_ptr_r]  <= pend_col_r;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign address    = address_r;
    assign chipselect = read_r;
    assign read       = read_r;
    assign write      = 1'b0;
    assign tile_valid = (count_r != '0);
    assign tile_data  = fifo_data_r[rd_ptr_r];
    assign tile_col   = fifo_col_r[rd_ptr_r];

endmodule

// File: doc/map_row_fetcher.md
Name: map_row_fetcher

Overview:
- Avalon-MM read master that walks one row of the 40x30 byte-wide tile map held in the single-port map RAM. The map RAM has fixed read latency 1, no waitrequest and unregistered q.
- Delivers the row's tile indices, in column order, as a valid/ready stream to the tile renderer / line-buffer filler.
- Sits between the video timing controller (issues one start per row) and the map RAM's Avalon slave port.

Parameters:
- MAP_COLS, 40, tiles per row.
- MAP_ROWS, 30, rows in map.
- ADDR_W, 11, map RAM word-address width.
- DATA_W, 8, tile index width.
- BASE_ADDR, 0, map word address of tile (0,0).
- FIFO_DEPTH, 4, output buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to fetch row `row`
- row  in  5  row index 0..MAP_ROWS-1, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last tile handshaked
- err  out  1  one-cycle pulse: start rejected, row out of range
- address  out  ADDR_W  Avalon address to map RAM
- chipselect  out  1  Avalon chipselect
- read  out  1  Avalon read strobe
- write  out  1  tied 0
- readdata  in  DATA_W  Avalon read data, valid the cycle after read
- tile_valid  out  1  stream data valid
- tile_ready  in  1  renderer accept
- tile_data  out  DATA_W  tile index
- tile_col  out  6  column of tile_data

Behaviour:
- Reset (reset==0 at a clk edge) clears all state. Outputs after reset: busy=0, done=0, err=0, read=0, chipselect=0, write=0, address=0, tile_valid=0, tile_data=0, tile_col=0. FIFO is emptied and in-flight reads are discarded.
- Reset mid-row aborts the row: no done pulse, and readdata returning after reset is ignored.
- States:
  - IDLE -> FETCH on start with row<MAP_ROWS. Latch row_base = BASE_ADDR + row*MAP_COLS and set col counters to 0.
  - IDLE, start with row>=MAP_ROWS: err pulses in the next cycle; state stays IDLE.
  - FETCH -> DRAIN after issuing the read for col MAP_COLS-1.
  - DRAIN -> IDLE when the last tile is handshaked. done pulses in the cycle after that handshake. busy falls in the same cycle done pulses.
- start while busy: ignored, with no err.
- Read issue:
  - read=chipselect=1 for exactly one cycle per column, with address=row_base+issue_col.
  - A read issues only when fifo_count + inflight < FIFO_DEPTH, so data can never be dropped (the RAM cannot stall).
  - inflight is 0 or 1: a read issued in cycle k returns readdata in cycle k+1, which is written into the FIFO at the end of k+1 together with its column.
- Output:
  - FIFO head drives tile_data and tile_col; tile_valid = !empty.
  - Handshake occurs when tile_valid && tile_ready. Data and column hold stable while valid && !ready.
  - Simultaneous push and pop in one cycle leaves the count unchanged.
- Latency: start accepted at edge E0; first read in cycle 1; first tile_valid in cycle 3.
- Throughput: with tile_ready held high, one tile per cycle sustained. A full row completes (done) 3+MAP_COLS cycles after start.
- Address arithmetic is modulo 2^ADDR_W. The last address is row_base+MAP_COLS-1 (1199 for row 29). The column counters wrap only via the state change, never past MAP_COLS-1.

Test Plan:
- Reset, then start row=0 with tile_ready=1 -> reads at addresses 0..39 on consecutive cycles; tile_col 0..39 with tile_data equal to mem[0..39]; first valid at cycle 3; done at cycle 43; busy low after.
- start row=29 with memory preloaded to mem[a]=a[7:0] -> addresses 1160..1199; tile_data 0x88..0xAF; done pulses once.
- row=29, tile_ready toggled 1-of-3 cycles -> no read while count+inflight==4; all 40 tiles delivered in order with no loss or duplication; data stable while stalled.
- start row=30, and separately row=31 -> err pulses one cycle after each; no read asserted; busy stays 0.
- Second start mid-row 5 -> ignored, with no err; only row 5's 40 tiles emitted.
- reset=0 asserted at tile 17 with a read in flight -> all outputs return to reset values next cycle; no done pulse; new start row=1 fetches cleanly from address 40.
